// File: rtl/szg_dac_spi_master_if.sv
// Command handshake and DAC pin bundle for the SYZYGY DAC Pod SPI engine.
// Handshake: spi_done is a ready level. A command is accepted on any clk edge where
// spi_done=1 and spi_send=1. spi_done then drops for the whole frame, and
// spi_send is ignored while it is low.
interface szg_dac_spi_master_if;
    logic [5:0] spi_reg;
    logic [7:0] spi_data_in;
    logic       spi_send;
    logic       spi_rw;
    logic       spi_done;
    logic [7:0] spi_data_out;
    logic       dac_cs_n;
    logic       dac_sclk;
    logic       dac_sdio_o;
    logic       dac_sdio_oe;
    logic       dac_sdio_i;

    modport master (
        output spi_reg, spi_data_in, spi_send, spi_rw,
        input  spi_done, spi_data_out
    );

    modport slave (
        input  spi_reg, spi_data_in, spi_send, spi_rw, dac_sdio_i,
        output spi_done, spi_data_out, dac_cs_n, dac_sclk, dac_sdio_o, dac_sdio_oe
    );

    modport pins (
        input  dac_cs_n, dac_sclk, dac_sdio_o, dac_sdio_oe,
        output dac_sdio_i
    );
endinterface

// File: rtl/szg_dac_spi_master.sv
// 16-bit 3-wire SPI engine for the AD911x DAC Pod: {rw,0,reg[5:0],data[7:0]}, MSB first.
// Define SZG_DAC_SPI_READBACK_EN to release SDIO and capture the data byte on read frames.
module szg_dac_spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    szg_dac_spi_master_if.slave  bus,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_BIT_HIGH = 3'd2,
        S_BIT_LOW  = 3'd3,
        S_HOLD     = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] shreg_q, shreg_d;
    logic        done_q, done_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        oe_q, oe_d;
    logic        phase_end;
    logic        rw_eff;

`ifdef SZG_DAC_SPI_READBACK_EN
    logic        rw_q, rw_d;
    logic [7:0]  rd_q, rd_d;
    assign rw_eff = bus.spi_rw;
`else
    logic        unused_pins;
    assign rw_eff      = 1'b0;
    assign unused_pins = bus.dac_sdio_i ^ bus.spi_rw;
`endif

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        done_d     = done_q;
        data_out_d = data_out_q;
        oe_d       = oe_q;
`ifdef SZG_DAC_SPI_READBACK_EN
        rw_d       = rw_q;
        rd_d       = rd_q;
`endif
        phase_end  = (div_q == DIV_LAST);

        if (state_q == S_IDLE) begin
            if (bus.spi_send) begin
                shreg_d = {rw_eff, 1'b0, bus.spi_reg, bus.spi_data_in};
                state_d = S_SETUP;
                div_d   = '0;
                bit_d   = '0;
                done_d  = 1'b0;
`ifdef SZG_DAC_SPI_READBACK_EN
                rw_d    = bus.spi_rw;
`endif
            end
        end else if (!phase_end) begin
            div_d = div_q + 16'd1;
        end else begin
            div_d = '0;
            case (state_q)
                S_SETUP: state_d = S_BIT_HIGH;
                S_BIT_HIGH: begin
                    // bit_q counts completed high phases; the 16th ends the serial data.
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_BIT_LOW;
                        shreg_d = {shreg_q[14:0], 1'b0};
`ifdef SZG_DAC_SPI_READBACK_EN
                        if (rw_q && bit_q == 5'd7) oe_d = 1'b0;
`endif
                    end
                end
                S_BIT_LOW: begin
                    state_d = S_BIT_HIGH;
`ifdef SZG_DAC_SPI_READBACK_EN
                    // Rising edges into high phases 9..16 carry data bits 7..0.
                    if (bit_q >= 5'd8) rd_d = {rd_q[6:0], bus.dac_sdio_i};
`endif
                end
                S_HOLD: begin
                    state_d = S_GAP;
                    oe_d    = 1'b1;
                end
                S_GAP: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`ifdef SZG_DAC_SPI_READBACK_EN
                    if (rw_q) data_out_d = rd_q;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Pin levels follow the next state so they are registered alongside it.
        cs_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
        sclk_d = (state_d == S_BIT_HIGH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            done_q     <= 1'b1;
            data_out_q <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            oe_q       <= 1'b1;
`ifdef SZG_DAC_SPI_READBACK_EN
            rw_q       <= 1'b0;
            rd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            oe_q       <= oe_d;
`ifdef SZG_DAC_SPI_READBACK_EN
            rw_q       <= rw_d;
            rd_q       <= rd_d;
`endif
        end
    end

    assign bus.spi_done     = done_q;
    assign bus.spi_data_out = data_out_q;
    assign bus.dac_cs_n     = cs_n_q;
    assign bus.dac_sclk     = sclk_q;
    assign bus.dac_sdio_o   = shreg_q[15];
    assign bus.dac_sdio_oe  = oe_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_szg_dac_spi_master.sv
// Self-checking bench for szg_dac_spi_master: pin-level frame monitor, DAC slave model,
// and a frame/timing reference derived from the command fields.
module tb_szg_dac_spi_master;
    localparam int CLK_DIV = 4;
`ifdef SZG_DAC_SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    szg_dac_spi_master_if bus();

    szg_dac_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    // Monitor / DAC slave model, sampled on the falling clk edge.
    logic        prev_sclk = 1'b0;
    logic        prev_cs_n = 1'b1;
    logic [15:0] cap = '0;
    int          nbits = 0;
    int          falls = 0;
    int          aborted = 0;
    int          oe_low_total = 0;
    logic [7:0]  slave_byte = 8'h00;

    always @(negedge clk) begin
        if (!bus.dac_cs_n && prev_cs_n) begin
            cap = '0; nbits = 0; falls = 0;
        end
        if (!bus.dac_cs_n) begin
            if (bus.dac_sclk && !prev_sclk) begin
                cap = {cap[14:0], bus.dac_sdio_o};
                nbits++;
            end
            if (!bus.dac_sclk && prev_sclk) falls++;
        end
        bus.dac_sdio_i = (falls >= 8 && falls <= 15) ? slave_byte[15 - falls] : 1'b0;
        if (!bus.dac_sdio_oe) oe_low_total++;
        if (bus.dac_cs_n && !prev_cs_n) begin
            if (nbits == 16) got_q.push_back(cap);
            else aborted++;
        end
        prev_sclk = bus.dac_sclk;
        prev_cs_n = bus.dac_cs_n;
    end

    function automatic logic [15:0] model_frame(input logic [5:0] r, input logic [7:0] d, input bit rw);
        logic [7:0] instr;
        instr = {rw & RB, 1'b0, r};
        return {instr, d};
    endfunction

    task automatic send_cmd(input logic [5:0] r, input logic [7:0] d, input bit rw);
        int n = 0;
        while (bus.spi_done !== 1'b1 && n < 2000) begin
            @(negedge clk); n++;
        end
        total++;
        if (bus.spi_done !== 1'b1) begin
            $display("FAIL send_wait: spi_done=%b required 1 within 2000 cycles", bus.spi_done);
            bad++;
        end
        bus.spi_reg = r; bus.spi_data_in = d; bus.spi_rw = rw; bus.spi_send = 1'b1;
        exp_q.push_back(model_frame(r, d, rw));
        @(negedge clk);
        bus.spi_send = 1'b0;
        bus.spi_reg = 6'($urandom); bus.spi_data_in = 8'($urandom); bus.spi_rw = 1'($urandom);
        total++;
        if (bus.spi_done !== 1'b0) begin
            $display("FAIL done_after_strobe: spi_done=%b required 0", bus.spi_done);
            bad++;
        end
    endtask

    // Starts on the first frame cycle; returns at the first spi_done-high cycle.
    task automatic wait_done(output int n, output int low);
        n = 0; low = 0;
        while (bus.spi_done !== 1'b1 && n < 2000) begin
            if (bus.dac_cs_n === 1'b0) low++;
            n++;
            @(negedge clk);
        end
        total++;
        if (bus.spi_done !== 1'b1) begin
            $display("FAIL done_timeout: spi_done=%b after %0d cycles required 1", bus.spi_done, n);
            bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.spi_send = 1'b0; bus.spi_reg = '0; bus.spi_data_in = '0; bus.spi_rw = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.dac_cs_n !== 1'b1) begin $display("FAIL reset_cs_n: got %b required 1", bus.dac_cs_n); bad++; end
        total++; if (bus.dac_sclk !== 1'b0) begin $display("FAIL reset_sclk: got %b required 0", bus.dac_sclk); bad++; end
        total++; if (bus.spi_done !== 1'b1) begin $display("FAIL reset_done: got %b required 1", bus.spi_done); bad++; end
        total++; if (bus.dac_sdio_o !== 1'b0) begin $display("FAIL reset_sdio_o: got %b required 0", bus.dac_sdio_o); bad++; end
        total++; if (bus.dac_sdio_oe !== 1'b1) begin $display("FAIL reset_sdio_oe: got %b required 1", bus.dac_sdio_oe); bad++; end
        total++; if (bus.spi_data_out !== 8'h00) begin $display("FAIL reset_data_out: got %h required 00", bus.spi_data_out); bad++; end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_frames(input string name);
        logic [15:0] e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin
                $display("FAIL %s_missing: no frame captured, required %h", name, e);
                bad++;
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    $display("FAIL %s_frame: got %h required %h", name, g, e);
                    bad++;
                end
            end
        end
        total++;
        if (got_q.size() != 0) begin
            $display("FAIL %s_extra: %0d unexpected frames, required 0", name, got_q.size());
            bad++;
            got_q.delete();
        end
    endtask

    task automatic test_single_write();
        int n, low, oe0;
        oe0 = oe_low_total;
        send_cmd(6'h05, 8'h80, 1'b0);
        wait_done(n, low);
        total++; if (low != 33 * CLK_DIV) begin $display("FAIL single_cs_low: got %0d required %0d", low, 33 * CLK_DIV); bad++; end
        total++; if (n != 34 * CLK_DIV) begin $display("FAIL single_done_at: got %0d required %0d", n, 34 * CLK_DIV); bad++; end
        total++; if (oe_low_total != oe0) begin $display("FAIL single_oe: got %0d low cycles required 0", oe_low_total - oe0); bad++; end
        check_frames("single");
    endtask

    task automatic test_back_to_back();
        logic [5:0] regs[4] = '{6'h05, 6'h08, 6'h04, 6'h07};
        logic [7:0] dats[4] = '{8'h80, 8'h80, 8'h9F, 8'h8A};
        int n, low;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) send_cmd(regs[i], dats[i], 1'b0);
            else send_cmd(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), 1'b0);
            wait_done(n, low);
            total++;
            if (low != 33 * CLK_DIV) begin $display("FAIL b2b_cs_low: frame %0d got %0d required %0d", i, low, 33 * CLK_DIV); bad++; end
        end
        check_frames("b2b");
    endtask

    task automatic test_busy_ignore();
        int n, low;
        send_cmd(6'h15, 8'h6C, 1'b0);
        repeat (39) @(negedge clk);
        bus.spi_reg = 6'h3F; bus.spi_data_in = 8'hFF; bus.spi_rw = 1'b0; bus.spi_send = 1'b1;
        @(negedge clk);
        bus.spi_send = 1'b0;
        wait_done(n, low);
        repeat (300) @(negedge clk);
        total++; if (bus.spi_done !== 1'b1) begin $display("FAIL busy_done: got %b required 1", bus.spi_done); bad++; end
        total++; if (bus.dac_cs_n !== 1'b1) begin $display("FAIL busy_cs_n: got %b required 1", bus.dac_cs_n); bad++; end
        check_frames("busy");
    endtask

    task automatic test_reset_mid();
        int n, low, ab0;
        ab0 = aborted;
        send_cmd(6'h12, 8'h34, 1'b0);
        void'(exp_q.pop_back());
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.dac_cs_n !== 1'b1) begin $display("FAIL midrst_cs_n: got %b required 1", bus.dac_cs_n); bad++; end
        total++; if (bus.dac_sclk !== 1'b0) begin $display("FAIL midrst_sclk: got %b required 0", bus.dac_sclk); bad++; end
        total++; if (bus.spi_done !== 1'b1) begin $display("FAIL midrst_done: got %b required 1", bus.spi_done); bad++; end
        reset = 1'b0;
        @(negedge clk);
        total++; if (aborted != ab0 + 1) begin $display("FAIL midrst_abort: got %0d aborted required %0d", aborted - ab0, 1); bad++; end
        send_cmd(6'h04, 8'h81, 1'b0);
        wait_done(n, low);
        total++; if (n != 34 * CLK_DIV) begin $display("FAIL midrst_done_at: got %0d required %0d", n, 34 * CLK_DIV); bad++; end
        check_frames("midrst");
    endtask

    task automatic test_read(input logic [5:0] r, input logic [7:0] sb);
        int n, low, oe0;
        logic [15:0] e, g, mask;
        logic [7:0]  exp_out, prev_out;
        prev_out = bus.spi_data_out;
        slave_byte = sb;
        oe0 = oe_low_total;
        send_cmd(r, 8'($urandom), 1'b1);
        wait_done(n, low);
        @(negedge clk);
        mask    = RB ? 16'hFF00 : 16'hFFFF;
        exp_out = RB ? sb : prev_out;
        e = exp_q.pop_front();
        total++;
        if (got_q.size() == 0) begin
            $display("FAIL read_missing: no frame captured, required %h", e);
            bad++;
        end else begin
            g = got_q.pop_front();
            if ((g & mask) !== (e & mask)) begin
                $display("FAIL read_frame: got %h required %h (mask %h)", g, e, mask);
                bad++;
            end
        end
        total++;
        if (oe_low_total - oe0 != (RB ? 17 * CLK_DIV : 0)) begin
            $display("FAIL read_oe_low: got %0d cycles required %0d", oe_low_total - oe0, RB ? 17 * CLK_DIV : 0);
            bad++;
        end
        total++;
        if (bus.spi_data_out !== exp_out) begin
            $display("FAIL read_data_out: got %h required %h", bus.spi_data_out, exp_out);
            bad++;
        end
        total++;
        if (bus.dac_sdio_oe !== 1'b1) begin $display("FAIL read_oe_idle: got %b required 1", bus.dac_sdio_oe); bad++; end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_read(6'h04, 8'hA5);
        test_read(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        send_cmd(6'h2A, 8'($urandom), 1'b0);
        begin
            int n, low;
            wait_done(n, low);
        end
        check_frames("final_write");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
